// File: rtl/parking_lot_controller.sv
// parking_lot_controller
//   Purpose : Synchronises and debounces one occupancy sensor per slot, keeps
//             registered parked/empty counts plus a full flag, and runs the
//             entry-barrier FSM (request / deny / timeout).
//   Latency : raw sensor edge -> parked update = 2 + DEBOUNCE + 1 cycles;
//             entry_req -> gate_open = 1 cycle; gate_clear -> close = 1 cycle.
//   Ports   : clk, rst_n (async active-low); slot_sensor[SLOTS] raw async inputs;
//             entry_req (level), gate_clear (1-cycle pulse);
//             parked/empty (CNT_W), full, gate_open, entry_deny (pulse),
//             gate_timeout (pulse), occ_change (pulse).
module parking_lot_controller #(
  parameter int SLOTS        = 8,
  parameter int CNT_W        = $clog2(SLOTS + 1),
  parameter int DEBOUNCE     = 4,
  parameter int GATE_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SLOTS-1:0] slot_sensor,
  input  logic             entry_req,
  input  logic             gate_clear,
  output logic [CNT_W-1:0] parked,
  output logic [CNT_W-1:0] empty,
  output logic             full,
  output logic             gate_open,
  output logic             entry_deny,
  output logic             gate_timeout,
  output logic             occ_change
);

  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TMR_W = $clog2(GATE_TIMEOUT);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(GATE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SLOTS_CNT = CNT_W'(SLOTS);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OPEN = 1'b1;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser per slot
  // ---------------------------------------------------------------------------
  logic [SLOTS-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= slot_sensor;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: a slot's stable value only follows sync after DEBOUNCE
  // consecutive differing samples. The counter update happens on the edge where
  // the count already equals DEBOUNCE-1, so the DEBOUNCE-th differing sample
  // is the one that commits.
  // ---------------------------------------------------------------------------
  logic [SLOTS-1:0]           stable_q, stable_d;
  logic [SLOTS-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Counts: popcount of the registered stable vector, so every slot that
  // committed on the same edge lands in a single parked update.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] parked_q, parked_d;
  logic [CNT_W-1:0] empty_q;
  logic             full_q;
  logic             occ_q;

  always_comb begin
    parked_d = '0;
    for (int i = 0; i < SLOTS; i++) begin
      parked_d = parked_d + CNT_W'(stable_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parked_q <= '0;
      empty_q  <= SLOTS_CNT;
      full_q   <= 1'b0;
      occ_q    <= 1'b0;
    end else begin
      parked_q <= parked_d;
      empty_q  <= SLOTS_CNT - parked_d;
      full_q   <= (parked_d == SLOTS_CNT);
      // A swap (one in, one out) leaves the popcount equal, hence no pulse.
      occ_q    <= (parked_d != parked_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Entry gate FSM
  // ---------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       deny_cnt_q, deny_cnt_d;  // free-runs mod 8 while denied
  logic             deny_q, deny_d;
  logic             tmo_q, tmo_d;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    deny_cnt_d = '0;
    deny_d     = 1'b0;
    tmo_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (entry_req) begin
          if (!full_q) begin
            state_d = ST_OPEN;
            timer_d = TMR_LOAD;
          end else begin
            // Pulse on the first denied sample, then every 8th while held.
            deny_d     = (deny_cnt_q == 3'd0);
            deny_cnt_d = deny_cnt_q + 3'd1;
          end
        end
      end
      ST_OPEN: begin
        // gate_clear has priority over a coincident expiry.
        if (gate_clear) begin
          state_d = ST_IDLE;
        end else if (timer_q == '0) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      deny_cnt_q <= '0;
      deny_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      deny_cnt_q <= deny_cnt_d;
      deny_q     <= deny_d;
      tmo_q      <= tmo_d;
    end
  end

  assign parked       = parked_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign gate_open    = (state_q == ST_OPEN);
  assign entry_deny   = deny_q;
  assign gate_timeout = tmo_q;
  assign occ_change   = occ_q;

endmodule

// File: tb/tb_parking_lot_controller.sv
// Self-checking bench for parking_lot_controller (SLOTS=8, DEBOUNCE=4,
// GATE_TIMEOUT=16). The reference model tracks, per slot, how many consecutive
// samples the synchronised sensor disagreed with the accepted value, and models
// the gate by the age of the current opening.
module tb_parking_lot_controller;

  localparam int SLOTS        = 8;
  localparam int DEBOUNCE     = 4;
  localparam int GATE_TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] slot_sensor;
  logic       entry_req;
  logic       gate_clear;
  logic [3:0] parked;
  logic [3:0] empty;
  logic       full;
  logic       gate_open;
  logic       entry_deny;
  logic       gate_timeout;
  logic       occ_change;

  int total;
  int bad;

  parking_lot_controller #(
    .SLOTS(SLOTS), .CNT_W(4), .DEBOUNCE(DEBOUNCE), .GATE_TIMEOUT(GATE_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .slot_sensor(slot_sensor), .entry_req(entry_req),
    .gate_clear(gate_clear), .parked(parked), .empty(empty), .full(full),
    .gate_open(gate_open), .entry_deny(entry_deny), .gate_timeout(gate_timeout),
    .occ_change(occ_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] dut_vec;
  assign dut_vec = {parked, empty, full, gate_open, entry_deny, gate_timeout, occ_change};

  // ---------------- reference model ----------------
  logic [7:0] m_s1, m_s2, m_stable;
  int         m_run [8];
  int         m_parked;
  bit         m_occ, m_open, m_deny, m_tmo;
  int         m_age, m_held;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
    m_parked = 0; m_occ = 0; m_open = 0; m_deny = 0; m_tmo = 0;
    m_age = 0; m_held = 0;
  endtask

  // One rising edge: all next values come from the pre-edge model state.
  task automatic model_edge();
    logic [7:0] ns;
    int         np;
    bit         was_full;
    ns       = m_stable;
    np       = $countones(m_stable);
    was_full = (m_parked == SLOTS);
    for (int i = 0; i < SLOTS; i++) begin
      if (m_s2[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DEBOUNCE) begin
          ns[i]    = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_occ    = (np != m_parked);
    m_parked = np;
    m_deny   = 0;
    m_tmo    = 0;
    if (!m_open) begin
      if (entry_req && !was_full) begin
        m_open = 1; m_age = 0; m_held = 0;
      end else if (entry_req && was_full) begin
        m_deny = (m_held % 8 == 0);
        m_held++;
      end else begin
        m_held = 0;
      end
    end else begin
      m_held = 0;
      if (gate_clear) m_open = 0;
      else if (m_age == GATE_TIMEOUT - 1) begin m_open = 0; m_tmo = 1; end
      else m_age++;
    end
    m_s2 = m_s1;
    m_s1 = slot_sensor;
    m_stable = ns;
  endtask

  function automatic logic [12:0] model_vec();
    logic [3:0] p;
    logic [3:0] e;
    p = 4'(m_parked);
    e = 4'(SLOTS - m_parked);
    return {p, e, (m_parked == SLOTS), m_open, m_deny, m_tmo, m_occ};
  endfunction

  // Inputs change at the falling edge; outputs are sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (dut_vec !== {4'd0, 4'd8, 5'b0}) begin
      bad++; $display("FAIL reset_outputs: got %h want %h", dut_vec, {4'd0, 4'd8, 5'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    int occ_at;
    int occ_n;
    occ_at = -1; occ_n = 0;
    slot_sensor = 8'b0000_0111;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL count_up_model cyc=%0d: got %h want %h", n, dut_vec, model_vec());
      end
      if (occ_change) begin occ_n++; if (occ_at < 0) occ_at = n; end
    end
    total++; if (occ_n != 1) begin bad++; $display("FAIL count_up_occ_pulses: got %0d want 1", occ_n); end
    total++; if (occ_at != 7) begin bad++; $display("FAIL count_up_latency: got %0d want 7", occ_at); end
    total++; if (parked !== 4'd3) begin bad++; $display("FAIL count_up_parked: got %0d want 3", parked); end
    total++; if (empty !== 4'd5) begin bad++; $display("FAIL count_up_empty: got %0d want 5", empty); end
  endtask

  task automatic test_glitch();
    slot_sensor[5] = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      cyc();
      if (n == 3) slot_sensor[5] = 1'b0;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL glitch_model cyc=%0d: got %h want %h", n, dut_vec, model_vec());
      end
      total++;
      if (parked !== 4'd3 || empty !== 4'd5 || occ_change !== 1'b0) begin
        bad++; $display("FAIL glitch_stable cyc=%0d: got parked=%0d empty=%0d occ=%b want 3 5 0",
                        n, parked, empty, occ_change);
      end
    end
  endtask

  task automatic test_full_deny();
    int dq[$];
    slot_sensor = 8'hFF;
    repeat (8) begin
      cyc();
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL fill_model: got %h want %h", dut_vec, model_vec());
      end
    end
    total++; if (full !== 1'b1 || empty !== 4'd0) begin
      bad++; $display("FAIL full_flag: got full=%b empty=%0d want 1 0", full, empty);
    end
    entry_req = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL deny_model cyc=%0d: got %h want %h", n, dut_vec, model_vec());
      end
      total++;
      if (gate_open !== 1'b0) begin bad++; $display("FAIL deny_gate_open cyc=%0d: got 1 want 0", n); end
      if (entry_deny) dq.push_back(n);
    end
    entry_req = 1'b0;
    cyc();
    total++;
    if (dq.size() != 3) begin
      bad++; $display("FAIL deny_count: got %0d want 3", dq.size());
    end else begin
      total++;
      if (dq[0] != 1 || dq[1] != 9 || dq[2] != 17) begin
        bad++; $display("FAIL deny_spacing: got %0d,%0d,%0d want 1,9,17", dq[0], dq[1], dq[2]);
      end
    end
  endtask

  task automatic test_entry();
    slot_sensor = 8'h1F;
    repeat (8) begin
      cyc();
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL entry_settle_model: got %h want %h", dut_vec, model_vec());
      end
    end
    total++; if (parked !== 4'd5) begin bad++; $display("FAIL entry_parked: got %0d want 5", parked); end
    entry_req = 1'b1;
    cyc();
    entry_req = 1'b0;
    total++; if (gate_open !== 1'b1) begin bad++; $display("FAIL entry_open: got %b want 1", gate_open); end
    for (int n = 2; n <= 5; n++) begin
      cyc();
      total++;
      if (dut_vec !== model_vec() || gate_open !== 1'b1) begin
        bad++; $display("FAIL entry_hold cyc=%0d: got %h want %h", n, dut_vec, model_vec());
      end
    end
    gate_clear = 1'b1;
    cyc();
    gate_clear = 1'b0;
    total++;
    if (gate_open !== 1'b0 || gate_timeout !== 1'b0) begin
      bad++; $display("FAIL entry_clear: got open=%b tmo=%b want 0 0", gate_open, gate_timeout);
    end
    total++;
    if (dut_vec !== model_vec()) begin
      bad++; $display("FAIL entry_clear_model: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_timeout();
    int open_n;
    int tmo_n;
    int tmo_at;
    open_n = 0; tmo_n = 0; tmo_at = -1;
    entry_req = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      if (n == 1) entry_req = 1'b0;
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL timeout_model cyc=%0d: got %h want %h", n, dut_vec, model_vec());
      end
      if (gate_open) open_n++;
      if (gate_timeout) begin tmo_n++; tmo_at = n; end
    end
    total++; if (open_n != 16) begin bad++; $display("FAIL timeout_open_len: got %0d want 16", open_n); end
    total++; if (tmo_n != 1 || tmo_at != 17) begin
      bad++; $display("FAIL timeout_pulse: got count=%0d at=%0d want 1 at 17", tmo_n, tmo_at);
    end
    // gate_clear on the expiry edge must suppress the timeout pulse.
    entry_req = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      cyc();
      if (n == 1) entry_req = 1'b0;
    end
    total++; if (gate_open !== 1'b1) begin bad++; $display("FAIL coincide_still_open: got 0 want 1"); end
    gate_clear = 1'b1;
    cyc();
    gate_clear = 1'b0;
    total++;
    if (gate_open !== 1'b0 || gate_timeout !== 1'b0) begin
      bad++; $display("FAIL coincide_clear: got open=%b tmo=%b want 0 0", gate_open, gate_timeout);
    end
    cyc();
    total++; if (gate_timeout !== 1'b0 || dut_vec !== model_vec()) begin
      bad++; $display("FAIL coincide_after: got %h want %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_swap_reset();
    slot_sensor = 8'h0F;
    repeat (8) cyc();
    total++; if (parked !== 4'd4) begin bad++; $display("FAIL swap_pre_parked: got %0d want 4", parked); end
    slot_sensor = 8'h8E;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      total++;
      if (dut_vec !== model_vec() || parked !== 4'd4 || occ_change !== 1'b0) begin
        bad++; $display("FAIL swap cyc=%0d: got %h want %h", n, dut_vec, model_vec());
      end
    end
    entry_req = 1'b1;
    cyc();
    entry_req = 1'b0;
    total++; if (gate_open !== 1'b1) begin bad++; $display("FAIL swap_open: got 0 want 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (gate_open !== 1'b0 || parked !== 4'd0 || empty !== 4'd8) begin
      bad++; $display("FAIL async_reset: got open=%b parked=%0d empty=%0d want 0 0 8",
                      gate_open, parked, empty);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int b;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        b = $urandom_range(0, 7);
        slot_sensor[b] = (n >= 1500) ? ($urandom_range(0, 4) != 0) : ~slot_sensor[b];
      end
      if ($urandom_range(0, 99) == 0) slot_sensor = 8'($urandom);
      if ($urandom_range(0, 5) == 0) entry_req = ~entry_req;
      gate_clear = ($urandom_range(0, 11) == 0);
      if (n == 2000) begin
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      cyc();
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL random_model cyc=%0d: got %h want %h", n, dut_vec, model_vec());
      end
    end
    gate_clear = 1'b0;
    entry_req  = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst_n       = 1'b0;
    slot_sensor = 8'h00;
    entry_req   = 1'b0;
    gate_clear  = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_count_up();
    test_glitch();
    test_full_deny();
    test_entry();
    test_timeout();
    test_swap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parking_lot_controller.md
Name: parking_lot_controller

Overview:
- Sequential, parametrised successor to the 8-slot combinational parking capacity counter.
- Synchronises and debounces one occupancy sensor per slot.
- Maintains registered parked/empty counts and a full flag.
- Drives an entry-gate FSM with a request/deny/timeout protocol. Sits between the slot sensor array and the entry barrier and display logic.

Parameters:
- SLOTS, 8, number of parking slots (1..64).
- CNT_W, $clog2(SLOTS+1), width of the parked and empty counts.
- DEBOUNCE, 4, consecutive stable cycles required before a sensor change is accepted (>=1).
- GATE_TIMEOUT, 16, cycles the gate stays open without gate_clear before auto-close (>=2).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- slot_sensor  input  SLOTS  raw per-slot occupancy (1 = car present); asynchronous to clk.
- entry_req  input  1  car at entry barrier; level, sampled each cycle.
- gate_clear  input  1  car has passed the barrier; single-cycle pulse, synchronous.
- parked  output  CNT_W  number of debounced occupied slots.
- empty  output  CNT_W  SLOTS - parked.
- full  output  1  high when empty == 0.
- gate_open  output  1  barrier open command.
- entry_deny  output  1  one-cycle pulse: request refused because the lot is full.
- gate_timeout  output  1  one-cycle pulse: gate auto-closed without gate_clear.
- occ_change  output  1  one-cycle pulse when parked changes value.

Behaviour:
- Reset (async assert, sync deassert by the surrounding design):
  - parked=0, empty=SLOTS, full=0, gate_open=0, all pulses 0.
  - Sync flops, stable occupancy and debounce counters all 0; FSM in IDLE.
- Synchroniser: two flops per slot bit → sync[i].
- Debounce, per slot i:
  - If sync[i] == stable[i], counter resets to 0.
  - Otherwise the counter increments; when it reaches DEBOUNCE-1 while sync[i] still differs, stable[i] takes sync[i] on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE cycles never reaches stable.
- Counts:
  - parked is the registered popcount of stable, updated one cycle after stable changes.
  - empty = SLOTS - parked and full = (parked == SLOTS), both registered in the same cycle as parked.
  - Total latency from a raw edge to the parked update = 2 (sync) + DEBOUNCE + 1 cycles.
  - Multiple slots changing in the same cycle are all reflected in a single update.
- occ_change: asserted the cycle parked takes a new value. No pulse if simultaneous arrivals and departures leave parked unchanged.
- Gate FSM states: IDLE, OPEN.
  - IDLE, entry_req=1, full=0 → OPEN next cycle; gate_open=1; timer loaded with GATE_TIMEOUT-1.
  - IDLE, entry_req=1, full=1 → stay IDLE; entry_deny pulses for one cycle, then re-pulses every 8 cycles while the request is held and full.
  - OPEN, gate_clear=1 → IDLE; gate_open=0 next cycle.
  - OPEN, timer reaches 0 without gate_clear → IDLE; gate_timeout pulses for one cycle.
  - OPEN, entry_req is ignored. full rising while OPEN does not close the gate; the admitted car proceeds.
  - gate_clear and timer expiry in the same cycle: gate_clear wins, no gate_timeout.
  - gate_clear in IDLE is ignored.
- Arithmetic: all counts unsigned CNT_W bits. parked never exceeds SLOTS by construction; no wrap.
- Reset mid-operation: gate closes immediately (async), counts return to 0/SLOTS, debounce history is discarded.

Test Plan:
1. SLOTS=8, DEBOUNCE=4: after reset drive slot_sensor=8'b0000_0111 and hold → parked=3, empty=5, occ_change pulses exactly once, 7 cycles after the edge.
2. Glitch: pulse slot_sensor[5] high for 3 cycles then low → parked, empty and occ_change unchanged throughout.
3. Full lot: slot_sensor=8'hFF stable, hold entry_req=1 for 20 cycles → full=1, empty=0, gate_open stays 0, entry_deny pulses at cycles 0, 8, 16 of the request.
4. Entry: parked=5, entry_req=1 for 1 cycle → gate_open=1 next cycle; gate_clear at cycle 6 → gate_open=0 next cycle, no gate_timeout.
5. Timeout: GATE_TIMEOUT=16, open the gate, never pulse gate_clear → gate_open stays high exactly 16 cycles, gate_timeout pulses once at close; gate_clear and expiry coincident → no gate_timeout.
6. Swap and reset: slot 0 clears while slot 7 fills in the same cycle at parked=4 → parked stays 4, no occ_change. Assert rst_n=0 while OPEN → gate_open=0 immediately, parked=0, empty=8.
